led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Sequencer for the 8-bit LED shift datapath: seed mux, feedback mux, shifter, and LED register.
- Drives the mux selects, the register load, and the shifter function code, so the datapath runs a programmed pattern.
- Patterns: left-chase, right-chase, or ping-pong, stepping once every TICK_DIV clocks, for a set number of passes.
- Watches the registered LED value to detect endpoints and to recover from a lost pattern.

Parameters:
- TICK_DIV, 4, clocks per shift step (>=1); TICK_DIV=1 gives one step per clock.
- PASSES, 2, completed passes before finishing; 0 means run until stop.

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  begin pattern; sampled in IDLE only
- stop  in  1  abort; wins over every other event except clear
- mode  in  2  00 left-chase, 01 right-chase, 10 ping-pong, 11 treated as 10; latched on start
- led  in  8  registered LED value fed back from the datapath
- seed_sel  out  1  0 selects seed 8'h80, 1 selects seed 8'h01
- fb_sel  out  1  0 selects seed path, 1 selects LED feedback
- load  out  1  LED register load enable
- func  out  2  shifter function: 00 pass-through, 01 shift left 1, 10 shift right 1, 11 unused (never driven)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when finished
- pass_cnt  out  8  completed passes in the current run

Behaviour:
- clear (synchronous, active-high):
  - state becomes IDLE; tick counter, pass_cnt and latched mode become 0.
  - All outputs are 0.
  - clear mid-run aborts with no done pulse.
- States: IDLE, SEED, RUN_L, RUN_R, DONE. Outputs are Moore, except load/func in RUN_x, which depend on the tick and led.
- IDLE:
  - load=0, fb_sel=0, func=00.
  - On start, latch mode, zero pass_cnt, and go to SEED.
- SEED (exactly one cycle):
  - fb_sel=0, func=00, load=1.
  - seed_sel=0 (seed 0x80) for right-chase; seed_sel=1 (seed 0x01) for left-chase and ping-pong.
  - Tick counter cleared.
  - Next state: RUN_R for right-chase, RUN_L otherwise.
- RUN_L / RUN_R, general:
  - fb_sel=1; seed_sel holds its last value.
  - Tick counter counts 0..TICK_DIV-1, wraps, and keeps running across RUN_L/RUN_R changes.
  - Non-terminal tick: load=0, func=00.
- RUN_L / RUN_R, on the terminal tick, first matching rule wins:
  1. led==0 (pattern lost): go to SEED; pass not counted.
  2. RUN_L, led!=0x80: load=1, func=01.
  3. RUN_L, led==0x80, left-chase: pass_cnt+1, go to SEED.
  4. RUN_L, led==0x80, ping-pong: load=1, func=10, go to RUN_R (reversal in the same step).
  5. RUN_R, led!=0x01: load=1, func=10.
  6. RUN_R, led==0x01, right-chase: pass_cnt+1, go to SEED.
  7. RUN_R, led==0x01, ping-pong: pass_cnt+1, load=1, func=01, go to RUN_L.
- Pass completion:
  - Any rule that increments pass_cnt to a value equal to PASSES (PASSES!=0) goes to DONE instead, with load=0.
  - pass_cnt saturates at 255 when PASSES=0.
- DONE (one cycle): done=1, busy=1, load=0, then IDLE.
- stop:
  - In SEED, RUN_x or DONE: next state IDLE, load=0 in that cycle, no done pulse.
  - stop together with start in IDLE: stay in IDLE.
- start while busy is ignored.
- Latency: start sampled in cycle N → SEED in N+1 → LED holds its seed from N+2.

Test Plan:
- TICK_DIV=1, PASSES=1, ping-pong; start in cycle 0 → SEED in cycle 1; led=0x01 in cycle 2; led=0x80 in cycle 9; led=0x40 in cycle 10; led=0x01 in cycle 16; done=1 only in cycle 17; pass_cnt=1; busy low from cycle 18.
- TICK_DIV=4, left-chase, PASSES=2 → load high on every 4th RUN cycle only; led walks 0x01→0x80, reseeds to 0x01 (pass_cnt=1), walks again; done after the second 0x80.
- Right-chase, TICK_DIV=1 → seed_sel=0; led sequence 0x80,0x40,…,0x01, then reseed to 0x80; func never equals 01.
- Force led=0 through the bench datapath mid-RUN_L → next state SEED, led=0x01 two cycles later, pass_cnt unchanged.
- stop asserted in RUN_R → IDLE next cycle, load=0, done never pulses. clear asserted mid-run → all outputs 0 on the next edge.
- PASSES=0, ping-pong, 3 round trips → pass_cnt=3, no done. start pulsed while busy → ignored; mode=11 behaves exactly as ping-pong.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// Sequencer for the 8-bit LED shift datapath (seed mux -> feedback mux ->
// shifter -> LED register). It drives the mux selects, the register load and
// the shifter function code. The result is a left-chase, right-chase or
// ping-pong pattern that advances one position every TICK_DIV clocks. It stops
// after PASSES completed passes, or runs until stop when PASSES is 0.
//
// The registered LED value is fed back. It is used to find the pattern ends,
// and to reseed when the pattern has been lost (led == 0).
//
// Parameters
//   TICK_DIV  clocks per shift step (>= 1)
//   PASSES    completed passes before DONE; 0 = run until stop
//
// Ports
//   clk       rising-edge clock
//   clear     synchronous active-high reset
//   start     begin a pattern (sampled in IDLE only)
//   stop      abort; beats everything except clear
//   mode      00 left-chase, 01 right-chase, 10/11 ping-pong (latched on start)
//   led       registered LED value from the datapath
//   seed_sel  0 = seed 8'h80, 1 = seed 8'h01
//   fb_sel    0 = seed path, 1 = LED feedback
//   load      LED register load enable
//   func      shifter code: 00 pass, 01 shift left, 10 shift right
//   busy      high in every state except IDLE
//   done      one-cycle pulse when the programmed passes are complete
//   pass_cnt  passes completed in the current run
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int PASSES   = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [7:0] led,
    output logic       seed_sel,
    output logic       fb_sel,
    output logic       load,
    output logic [1:0] func,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN_L,
        S_RUN_R,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_LEFT  = 2'b00,
        M_RIGHT = 2'b01,
        M_PING  = 2'b10
    } pmode_t;

    localparam logic [1:0] FN_PASS = 2'b00;
    localparam logic [1:0] FN_SHL  = 2'b01;
    localparam logic [1:0] FN_SHR  = 2'b10;

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // A pass target above 255 can never be reached by the 8-bit counter, so it
    // behaves like "run until stop".
    localparam bit            PASS_LIMITED = (PASSES > 0) && (PASSES < 256);
    localparam logic [8:0]    PASS_TARGET  = 9'(PASS_LIMITED ? PASSES : 0);

    state_t        state;
    state_t        state_n;
    pmode_t        mode_q;
    logic [TW-1:0] tick;
    logic          tick_last;
    logic          pass_inc;
    logic          pass_final;

    // Mode 11 is an alias for ping-pong.
    function automatic pmode_t norm_mode(input logic [1:0] m);
        case (m)
            2'b00:   return M_LEFT;
            2'b01:   return M_RIGHT;
            default: return M_PING;
        endcase
    endfunction

    assign tick_last  = (tick == TICK_LAST);
    assign pass_final = PASS_LIMITED && (({1'b0, pass_cnt} + 9'd1) == PASS_TARGET);

    // Next state plus the Mealy outputs (load/func) that react to tick and led.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_n  = state;
        load     = 1'b0;
        func     = FN_PASS;
        pass_inc = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) state_n = S_SEED;
            end

            S_SEED: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else begin
                    load    = 1'b1;
                    state_n = (mode_q == M_RIGHT) ? S_RUN_R : S_RUN_L;
                end
            end

            S_RUN_L, S_RUN_R: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (tick_last) begin
                    if (led == 8'h00) begin
                        // Pattern lost: reseed without counting a pass.
                        state_n = S_SEED;
                    end else if (state == S_RUN_L) begin
                        if (led != 8'h80) begin
                            load = 1'b1;
                            func = FN_SHL;
                        end else if (mode_q == M_PING) begin
                            // Reverse at the top in the same step.
                            load    = 1'b1;
                            func    = FN_SHR;
                            state_n = S_RUN_R;
                        end else begin
                            pass_inc = 1'b1;
                            state_n  = S_SEED;
                        end
                    end else begin
                        if (led != 8'h01) begin
                            load = 1'b1;
                            func = FN_SHR;
                        end else if (mode_q == M_PING) begin
                            // A ping-pong pass ends at the bottom and bounces.
                            pass_inc = 1'b1;
                            load     = 1'b1;
                            func     = FN_SHL;
                            state_n  = S_RUN_L;
                        end else begin
                            pass_inc = 1'b1;
                            state_n  = S_SEED;
                        end
                    end

                    if (pass_inc && pass_final) begin
                        state_n = S_DONE;
                        load    = 1'b0;
                        func    = FN_PASS;
                    end
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, counters and the Moore outputs. The Moore outputs are registered
    // from the next state, so they line up with the state they describe.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, whatever order the lines are in.
        if (clear) begin
            state    <= S_IDLE;
            mode_q   <= M_LEFT;
            tick     <= '0;
            pass_cnt <= 8'd0;
            seed_sel <= 1'b0;
            fb_sel   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= state_n;
            busy   <= (state_n != S_IDLE);
            done   <= (state_n == S_DONE);
            fb_sel <= (state_n == S_RUN_L) || (state_n == S_RUN_R);

            if (state == S_IDLE && state_n == S_SEED) begin
                mode_q   <= norm_mode(mode);
                seed_sel <= (norm_mode(mode) != M_RIGHT);
                pass_cnt <= 8'd0;
            end

            if (pass_inc && pass_cnt != 8'hFF) begin
                pass_cnt <= pass_cnt + 8'd1;
            end

            // The tick keeps running across RUN_L/RUN_R reversals.
            if (state == S_SEED) begin
                tick <= '0;
            end else if (state == S_RUN_L || state == S_RUN_R) begin
                tick <= tick_last ? '0 : tick + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Three controllers, each with its own behavioural LED datapath:
//   g0: TICK_DIV=1, PASSES=1
//   g1: TICK_DIV=4, PASSES=2
//   g2: TICK_DIV=1, PASSES=0 (run until stop)
//
// The expected per-cycle behaviour comes from a position walker. It moves a
// single lit bit across the LED bar: it holds each position for TICK_DIV
// cycles, counts passes at the pattern ends, and reseeds, bounces or finishes.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            clear;
    logic            stop;
    logic [1:0]      mode;
    logic [2:0]      start_v;
    logic [2:0]      force_zero;

    logic [2:0][7:0] led_w;
    logic [2:0][7:0] pc_w;
    logic [2:0][1:0] func_w;
    logic [2:0]      seed_sel_w;
    logic [2:0]      fb_w;
    logic [2:0]      load_w;
    logic [2:0]      busy_w;
    logic [2:0]      done_w;

    led_pattern_ctrl #(.TICK_DIV(1), .PASSES(1)) u0 (
        .clk(clk), .clear(clear), .start(start_v[0]), .stop(stop), .mode(mode),
        .led(led_w[0]), .seed_sel(seed_sel_w[0]), .fb_sel(fb_w[0]), .load(load_w[0]),
        .func(func_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass_cnt(pc_w[0])
    );

    led_pattern_ctrl #(.TICK_DIV(4), .PASSES(2)) u1 (
        .clk(clk), .clear(clear), .start(start_v[1]), .stop(stop), .mode(mode),
        .led(led_w[1]), .seed_sel(seed_sel_w[1]), .fb_sel(fb_w[1]), .load(load_w[1]),
        .func(func_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass_cnt(pc_w[1])
    );

    led_pattern_ctrl #(.TICK_DIV(1), .PASSES(0)) u2 (
        .clk(clk), .clear(clear), .start(start_v[2]), .stop(stop), .mode(mode),
        .led(led_w[2]), .seed_sel(seed_sel_w[2]), .fb_sel(fb_w[2]), .load(load_w[2]),
        .func(func_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass_cnt(pc_w[2])
    );

    // Behavioural datapath: seed mux -> feedback mux -> shifter -> LED register.
    for (genvar g = 0; g < 3; g++) begin : g_dp
        logic [7:0] led_r;
        logic [7:0] mux;
        assign mux      = fb_w[g] ? led_r : (seed_sel_w[g] ? 8'h01 : 8'h80);
        assign led_w[g] = led_r;
        always_ff @(posedge clk) begin
            if (clear || force_zero[g]) begin
                led_r <= 8'h00;
            end else if (load_w[g]) begin
                case (func_w[g])
                    2'b00:   led_r <= mux;
                    2'b01:   led_r <= {mux[6:0], 1'b0};
                    2'b10:   led_r <= {1'b0, mux[7:1]};
                    default: led_r <= led_r;
                endcase
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int td_of(input int g);
        return (g == 1) ? 4 : 1;
    endfunction

    function automatic int ps_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 0);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] led;
        bit         led_dc;
        bit         busy;
        bit         done;
        bit         load;
        logic [1:0] func;
        logic [7:0] pc;
        int         fb;      // 0, 1, or 2 = don't care
    } exp_t;

    exp_t model_q[$];

    function automatic exp_t rec(input int b, input bit ld, input logic [1:0] fn, input int pc);
        exp_t r;
        r.led    = 8'(1 << b);
        r.led_dc = 1'b0;
        r.busy   = 1'b1;
        r.done   = 1'b0;
        r.load   = ld;
        r.func   = fn;
        r.pc     = 8'(pc);
        r.fb     = 1;
        return r;
    endfunction

    // One record per cycle, starting with the seed cycle after start.
    function automatic void build_model(input int td, input int passes, input int md, input int max_len);
        exp_t r;
        int   b, d, pc, npc;
        bit   ping, right, fin, reseed;
        ping  = (md >= 2);
        right = (md == 1);
        pc    = 0;
        fin   = 1'b0;
        model_q.delete();
        while (!fin && model_q.size() < max_len) begin
            r = rec(0, 1'b1, 2'b00, pc);
            r.led_dc = 1'b1;
            r.fb     = 0;
            model_q.push_back(r);
            b      = right ? 7 : 0;
            d      = right ? -1 : 1;
            reseed = 1'b0;
            while (!reseed && !fin && model_q.size() < max_len) begin
                for (int k = 0; k < td - 1; k++) model_q.push_back(rec(b, 1'b0, 2'b00, pc));
                if ((d > 0 && b != 7) || (d < 0 && b != 0)) begin
                    model_q.push_back(rec(b, 1'b1, (d > 0) ? 2'b01 : 2'b10, pc));
                    b += d;
                end else if (ping && d > 0) begin
                    model_q.push_back(rec(b, 1'b1, 2'b10, pc));
                    d = -1;
                    b = 6;
                end else begin
                    npc = (pc < 255) ? pc + 1 : 255;
                    if (passes != 0 && npc == passes) begin
                        model_q.push_back(rec(b, 1'b0, 2'b00, pc));
                        r = rec(b, 1'b0, 2'b00, npc);
                        r.done = 1'b1;
                        r.fb   = 2;
                        model_q.push_back(r);
                        fin = 1'b1;
                    end else if (ping) begin
                        model_q.push_back(rec(b, 1'b1, 2'b01, pc));
                        d = 1;
                        b = 1;
                    end else begin
                        model_q.push_back(rec(b, 1'b0, 2'b00, pc));
                        reseed = 1'b1;
                    end
                    pc = npc;
                end
            end
        end
    endfunction

    // ---------------- run driver ----------------
    logic [7:0] trace_led  [0:400];
    logic       trace_done [0:400];
    logic       trace_busy [0:400];
    int         load_cnt;
    int         func01_cnt;

    // Called on a negedge with the instance idle. Cycle 0 = start cycle,
    // record i is checked in cycle i+1.
    task automatic run_check(input int g, input int md, input int abort_at, input int pulse_at);
        exp_t r;
        int   n;
        int   last;
        build_model(td_of(g), ps_of(g), md, 300);
        n = model_q.size();
        if (abort_at >= 0 && abort_at < n) n = abort_at + 1;
        last       = n - 1;
        load_cnt   = 0;
        func01_cnt = 0;
        mode       = 2'(md);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        for (int i = 0; i < n; i++) begin
            r          = model_q[i];
            start_v[g] = (i == pulse_at);
            trace_led[i+1]  = led_w[g];
            trace_done[i+1] = done_w[g];
            trace_busy[i+1] = busy_w[g];
            if (i == abort_at) begin
                stop = 1'b1;
                #1;
                check($sformatf("g%0d m%0d r%0d stop_load", g, md, i), 32'(load_w[g]), 32'd0);
            end else begin
                check($sformatf("g%0d m%0d r%0d busy", g, md, i), 32'(busy_w[g]), 32'(r.busy));
                check($sformatf("g%0d m%0d r%0d done", g, md, i), 32'(done_w[g]), 32'(r.done));
                check($sformatf("g%0d m%0d r%0d load", g, md, i), 32'(load_w[g]), 32'(r.load));
                check($sformatf("g%0d m%0d r%0d func", g, md, i), 32'(func_w[g]), 32'(r.func));
                check($sformatf("g%0d m%0d r%0d pass_cnt", g, md, i), 32'(pc_w[g]), 32'(r.pc));
                check($sformatf("g%0d m%0d r%0d seed_sel", g, md, i), 32'(seed_sel_w[g]), 32'(md != 1));
                if (!r.led_dc) check($sformatf("g%0d m%0d r%0d led", g, md, i), 32'(led_w[g]), 32'(r.led));
                if (r.fb != 2) check($sformatf("g%0d m%0d r%0d fb_sel", g, md, i), 32'(fb_w[g]), 32'(r.fb));
                if (load_w[g]) load_cnt++;
                if (func_w[g] == 2'b01) func01_cnt++;
            end
            @(negedge clk);
        end
        stop       = 1'b0;
        start_v[g] = 1'b0;
        trace_busy[n+1] = busy_w[g];
        check($sformatf("g%0d m%0d idle_pass_cnt", g, md), 32'(pc_w[g]), 32'(model_q[last].pc));
        for (int j = 0; j < 3; j++) begin
            check($sformatf("g%0d m%0d idle%0d busy", g, md, j), 32'(busy_w[g]), 32'd0);
            check($sformatf("g%0d m%0d idle%0d done", g, md, j), 32'(done_w[g]), 32'd0);
            check($sformatf("g%0d m%0d idle%0d load", g, md, j), 32'(load_w[g]), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input int g, input string tag);
        check({tag, " seed_sel"}, 32'(seed_sel_w[g]), 32'd0);
        check({tag, " fb_sel"},   32'(fb_w[g]),       32'd0);
        check({tag, " load"},     32'(load_w[g]),     32'd0);
        check({tag, " func"},     32'(func_w[g]),     32'd0);
        check({tag, " busy"},     32'(busy_w[g]),     32'd0);
        check({tag, " done"},     32'(done_w[g]),     32'd0);
        check({tag, " pass_cnt"}, 32'(pc_w[g]),       32'd0);
    endtask

    initial begin
        int g, md, ab, pu;
        clear      = 1'b1;
        stop       = 1'b0;
        mode       = 2'b00;
        start_v    = 3'b000;
        force_zero = 3'b000;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset g%0d", k));
        clear = 1'b0;
        @(negedge clk);

        // Ping-pong, one step per clock, one pass.
        run_check(0, 2, -1, -1);
        check("pp led c2",   32'(trace_led[2]),   32'h01);
        check("pp led c9",   32'(trace_led[9]),   32'h80);
        check("pp led c10",  32'(trace_led[10]),  32'h40);
        check("pp led c16",  32'(trace_led[16]),  32'h01);
        check("pp done c16", 32'(trace_done[16]), 32'd0);
        check("pp done c17", 32'(trace_done[17]), 32'd1);
        check("pp busy c18", 32'(trace_busy[18]), 32'd0);
        check("pp pass_cnt", 32'(pc_w[0]),        32'd1);

        // Left-chase, TICK_DIV=4, two passes.
        run_check(1, 0, -1, 5);
        check("lc led c33",   32'(trace_led[33]),  32'h80);
        check("lc led c35",   32'(trace_led[35]),  32'h01);
        check("lc done c66",  32'(trace_done[66]), 32'd0);
        check("lc done c67",  32'(trace_done[67]), 32'd1);
        check("lc load count", 32'(load_cnt),      32'd16);

        // Right-chase, reseed to 0x80 after the first pass, stop mid-run.
        run_check(2, 1, 15, -1);
        check("rc led c2",   32'(trace_led[2]),  32'h80);
        check("rc led c9",   32'(trace_led[9]),  32'h01);
        check("rc led c11",  32'(trace_led[11]), 32'h80);
        check("rc no shl",   32'(func01_cnt),    32'd0);
        check("rc pass_cnt", 32'(pc_w[2]),       32'd1);

        // Stop while in RUN_R.
        run_check(0, 2, 12, -1);

        // Mode 11 runs three round trips, then a stop. A start pulse lands mid-run.
        run_check(2, 3, 50, 20);
        check("pp3 pass_cnt", 32'(pc_w[2]), 32'd3);

        // Lost pattern: force led to 0 mid RUN_L, then clear mid-run.
        mode       = 2'b00;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("lost led c4", 32'(led_w[0]), 32'h04);
        force_zero[0] = 1'b1;
        @(negedge clk);
        force_zero[0] = 1'b0;
        check("lost led c5",  32'(led_w[0]),  32'h00);
        check("lost load c5", 32'(load_w[0]), 32'd0);
        check("lost busy c5", 32'(busy_w[0]), 32'd1);
        @(negedge clk);
        check("lost seed fb c6",   32'(fb_w[0]),   32'd0);
        check("lost seed load c6", 32'(load_w[0]), 32'd1);
        @(negedge clk);
        check("lost led c7",      32'(led_w[0]), 32'h01);
        check("lost pass_cnt c7", 32'(pc_w[0]),  32'd0);
        check("lost fb c7",       32'(fb_w[0]),  32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero(0, "clear mid-run");
        @(negedge clk);

        // Randomised runs against the model.
        for (int it = 0; it < 10; it++) begin
            g  = int'($urandom_range(0, 2));
            md = int'($urandom_range(0, 3));
            ab = (g == 2 || $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1;
            pu = int'($urandom_range(1, 12));
            run_check(g, md, ab, pu);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
